// File: rtl/arb_rr_bin.sv
// rtl/arb_rr_bin.sv - round-robin arbiter with hold limit, binary and one-hot grant
//
// bin2oht: binary index to one-hot decoder.
//   vld  in   1          decode enable; oht is all zeros when low
//   bin  in   WIDTH_LOG  binary index, expected < WIDTH
//   oht  out  WIDTH      one-hot decode of bin
//
// arb_rr_bin: shares one resource between WIDTH requesters.
//   clk      in   1          clock
//   rst_n    in   1          asynchronous active-low reset
//   req      in   WIDTH      request vector, held high while wanting/holding the resource
//   gnt_vld  out  1          a grant is active
//   gnt_bin  out  WIDTH_LOG  index of the granted requester, 0 when idle
//   gnt_oht  out  WIDTH      one-hot grant, all zeros when idle
//   pre      out  1          pulse in the first cycle of a grant created by preemption

module bin2oht #(
    parameter  int WIDTH          = 8,
    parameter  int SPLIT          = 2,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 vld,
    input  logic [WIDTH_LOG-1:0] bin,
    output logic [WIDTH-1:0]     oht
);

    localparam int GROUPS = (WIDTH + SPLIT - 1) / SPLIT;

    generate
        if (IMPLEMENTATION == 0) begin : g_tree
            // Two-level decode: the index is split into a group number (upper
            // bits) and a position inside the group (lower log2(SPLIT) bits).
            // Each output is the AND of one group line and one position line.
            logic [GROUPS-1:0] hi_hit;
            logic [SPLIT-1:0]  lo_hit;

            always_comb begin
                hi_hit = '0;
                lo_hit = '0;
                oht    = '0;
                for (int g = 0; g < GROUPS; g++) begin
                    hi_hit[g] = vld && ((32'(bin) / SPLIT) == g);
                end
                for (int j = 0; j < SPLIT; j++) begin
                    lo_hit[j] = ((32'(bin) % SPLIT) == j);
                end
                for (int i = 0; i < WIDTH; i++) begin
                    oht[i] = hi_hit[i / SPLIT] && lo_hit[i % SPLIT];
                end
            end
        end else begin : g_flat
            always_comb begin
                oht = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    oht[i] = vld && (32'(bin) == i);
                end
            end
        end
    endgenerate

endmodule

module arb_rr_bin #(
    parameter  int WIDTH          = 8,
    parameter  int SPLIT          = 2,
    parameter  int HOLD           = 16,
    parameter  int IMPLEMENTATION = 0,
    localparam int WIDTH_LOG      = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    output logic                 gnt_vld,
    output logic [WIDTH_LOG-1:0] gnt_bin,
    output logic [WIDTH-1:0]     gnt_oht,
    output logic                 pre
);

    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH_LOG-1:0] gnt_bin_q, gnt_bin_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
    logic                 pre_q, pre_d;

    logic [WIDTH-1:0]     owner_oh;
    logic [WIDTH-1:0]     others;
    logic [WIDTH_LOG-1:0] pick_all;
    logic [WIDTH_LOG-1:0] pick_oth;
    logic                 restart;   // a new tenure starts at this edge
    logic                 hold_exp;  // current owner has used up its tenure

    // First set bit of cand scanning ptr+1, ptr+2, ... modulo WIDTH.
    // Returns 0 when cand is empty; callers qualify with |cand.
    function automatic logic [WIDTH_LOG-1:0] rr_pick(
        input logic [WIDTH-1:0]     cand,
        input logic [WIDTH_LOG-1:0] ptr
    );
        logic [WIDTH_LOG-1:0] pick;
        logic                 hit;
        int                   idx;
        pick = '0;
        hit  = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            if (!hit && cand[idx]) begin
                hit  = 1'b1;
                pick = WIDTH_LOG'(idx);
            end
        end
        return pick;
    endfunction

    assign owner_oh = WIDTH'(1) << gnt_bin_q;
    assign others   = req & ~owner_oh;
    assign pick_all = rr_pick(req, ptr_q);
    assign pick_oth = rr_pick(others, ptr_q);

    always_comb begin
        state_d   = state_q;
        gnt_bin_d = gnt_bin_q;
        pre_d     = 1'b0;
        restart   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d   = BUSY;
                    gnt_bin_d = pick_all;
                    restart   = 1'b1;
                end
            end
            BUSY: begin
                if (req[gnt_bin_q]) begin
                    if (hold_exp && |others) begin
                        gnt_bin_d = pick_oth;
                        pre_d     = 1'b1;
                        restart   = 1'b1;
                    end
                end else if (|req) begin
                    // Owner released with others waiting: hand over with no
                    // idle cycle. A simultaneous expiry counts as a release.
                    gnt_bin_d = pick_all;
                    restart   = 1'b1;
                end else begin
                    state_d   = IDLE;
                    gnt_bin_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_bin_d = '0;
            end
        endcase
    end

    // The pointer tracks the latest grant only; it stays put while idle so the
    // next idle grant continues the rotation from the last owner.
    assign ptr_d = restart ? gnt_bin_d : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_bin_q <= '0;
            ptr_q     <= WIDTH_LOG'(WIDTH - 1);
            pre_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_bin_q <= gnt_bin_d;
            ptr_q     <= ptr_d;
            pre_q     <= pre_d;
        end
    end

    generate
        if (HOLD != 0) begin : g_hold
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Counts cycles of the current tenure, saturating at HOLD-1 so an
            // uncontested owner keeps the expiry flag without wrapping.
            always_comb begin
                cnt_d = cnt_q;
                if (restart || (state_q == IDLE)) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_W'(HOLD - 1)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign hold_exp = (cnt_q == CNT_W'(HOLD - 1));
        end else begin : g_no_hold
            assign hold_exp = 1'b0;
        end
    endgenerate

    assign gnt_vld = (state_q == BUSY);
    assign gnt_bin = gnt_bin_q;
    assign pre     = pre_q;

    bin2oht #(
        .WIDTH          (WIDTH),
        .SPLIT          (SPLIT),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_bin2oht (
        .vld (gnt_vld),
        .bin (gnt_bin_q),
        .oht (gnt_oht)
    );

endmodule

// File: doc/arb_rr_bin.md
Name: arb_rr_bin

Overview:
- Round-robin arbiter that shares one resource between WIDTH requesters.
- Holds each grant until the owner drops its request, or until a hold limit expires while other requesters are waiting.
- Grant is registered as a binary index (gnt_bin) plus valid; the one-hot grant vector is produced by an internal bin2oht instance.
- Sits in front of shared datapath resources (buses, memories, execution units) whose muxes take either a binary select or a one-hot select.

Parameters:
- WIDTH, 8, number of requesters; must be at least 2; need not be a power of 2.
- SPLIT, 2, tree split factor passed to bin2oht; must be a power of 2.
- HOLD, 16, maximum grant tenure in cycles while another request is pending; 0 means unlimited (no preemption).
- IMPLEMENTATION, 0, passed to bin2oht unchanged.
- WIDTH_LOG (localparam), $clog2(WIDTH), width of the binary grant index.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous assert, active-low
- req  input  WIDTH  request vector; req[i] is high while requester i wants or holds the resource
- gnt_vld  output  1  a grant is active
- gnt_bin  output  WIDTH_LOG  index of the granted requester; 0 when gnt_vld=0
- gnt_oht  output  WIDTH  one-hot grant; all zeros when gnt_vld=0
- pre  output  1  single-cycle pulse, high in the first cycle of a grant that was created by preemption

Behaviour:
- Reset (rst_n=0, asynchronous) sets:
  - gnt_vld=0, gnt_bin=0, pre=0.
  - ptr=WIDTH-1, so requester 0 has top priority after reset.
  - hold counter cnt=0; state=IDLE.
- gnt_oht is the combinational decode of the registered gnt_vld/gnt_bin through bin2oht(WIDTH, SPLIT, IMPLEMENTATION).
  - vld of bin2oht is driven by gnt_vld.
  - No path from req to any output without a register.
- Arbitration function sel(mask):
  - Picks the first set bit of req&mask, scanning indices ptr+1, ptr+2, ... with wrap modulo WIDTH.
  - Indices >= WIDTH are never produced.
- Latency: a request seen at a rising edge with no active grant produces gnt_vld=1 at that edge's output, i.e. 1 cycle from req to grant.
- States:
  - IDLE: if |req, grant sel(all); ptr and gnt_bin take the selected index; cnt=0; go to BUSY. Else stay, outputs 0.
  - BUSY, owner keeps request (req[gnt_bin]=1):
    - If HOLD!=0, cnt==HOLD-1 and req has another bit set: preempt. Grant sel(~onehot(gnt_bin)), pre=1 for one cycle, cnt=0, stay BUSY.
    - Else keep the grant; cnt increments and saturates at HOLD-1.
  - BUSY, owner drops its request (req[gnt_bin]=0):
    - If other requests are pending, re-grant back-to-back with no idle cycle: sel(all), cnt=0, pre=0.
    - Else gnt_vld=0, gnt_bin=0, go to IDLE.
- ptr always equals the index of the most recent grant. It is not updated while idle.
- A granted requester keeps its grant for as long as it holds req high, unless preempted; it never loses the grant in the same cycle it raises req.
- Simultaneous owner-release and hold expiry: treated as a release; pre=0.
- HOLD=1 with a competitor pending: preemption every cycle (pure rotation); pre=1 on each switch.
- Reset asserted mid-grant clears all outputs immediately (asynchronous). The first grant after deassertion goes to the lowest-indexed active requester.
- cnt width is $clog2(HOLD) (minimum 1). No counter is used when HOLD=0.

Test Plan:
1. Config WIDTH=4, HOLD=4. Reset, then req=4'b1010 held -> next edge gnt_vld=1, gnt_bin=1, gnt_oht=0010. req[1] dropped -> next edge gnt_bin=3, with no gap cycle.
2. req=4'b0011 held constantly, HOLD=4 -> grant 0 for 4 cycles, then gnt_bin=1 with pre=1 for one cycle, grant 1 for 4 cycles, then back to 0. Alternates indefinitely.
3. Single requester: req=4'b0100 held 20 cycles, HOLD=4 -> gnt_bin=2 for the whole time, pre never asserts. Drop req -> gnt_vld=0, gnt_oht=0000 next edge.
4. Wrap-around: last grant 3, then req=4'b1001 -> grant 0. With grant 0 active, drop req[0] -> grant 3.
5. WIDTH=5 (non-power-of-2), all req high, owner releases every cycle -> gnt_bin sequence 0,1,2,3,4,0. gnt_oht always has exactly one bit set within [4:0].
6. Assert rst_n=0 asynchronously mid-grant -> gnt_vld, gnt_oht and gnt_bin go to 0 before the next clk edge. After release with req=4'b1111 -> gnt_bin=0.
